gen_clk_div: RTL and testbench

GEN_CLK_DIV -- requirements
Module: gen_clk_div

---
 rtl/gen_clk_div.sv | 107 ++++++++++
 tb/tb_gen_clk_div.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/gen_clk_div.sv
// Multi-channel programmable clock divider. Each channel produces a flop-driven
// divided clock and edge tick; new ratios are queued and take effect at a period boundary.
module gen_clk_div #(
   parameter int NCH     = 2,
   parameter int DIVW    = 8,
   parameter int DEF_DIV = 2
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NCH-1:0]                           en,
   input  logic                                     sync,
   input  logic                                     cfg_valid,
   input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
   input  logic [DIVW-1:0]                          cfg_div,
   output logic                                     cfg_ready,
   output logic [NCH-1:0]                           div_clk,
   output logic [NCH-1:0]                           tick
);

   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   function automatic logic [DIVW-1:0] sat_div(input logic [DIVW-1:0] x);
      return (x < DIVW'(2)) ? DIVW'(2) : x;
   endfunction

   function automatic logic [DIVW:0] half_up(input logic [DIVW-1:0] x);
      return ({1'b0, x} + (DIVW+1)'(1)) >> 1;
   endfunction

   logic [NCH-1:0] pv_vec;
   logic [NCH-1:0] acc;

   // Out-of-range channels never match, so they read ready and are dropped.
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if (cfg_ch == CHW'(i) && pv_vec[i]) cfg_ready = 1'b0;
      end
      if (rst) cfg_ready = 1'b1;
   end

   always_comb begin
      acc = '0;
      if (cfg_valid && cfg_ready && !rst) begin
         for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CHW'(i)) acc[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [DIVW-1:0] d_q, cnt_q, p_q;
      logic [DIVW-1:0] d_nxt, cnt_nxt;
      logic            pv_q, en_q, div_q, tick_q;
      logic            pv_nxt, load;

      // A period boundary is a wrap, a sync, or the first enabled edge.
      always_comb begin
         d_nxt   = d_q;
         cnt_nxt = cnt_q;
         pv_nxt  = pv_q;
         load    = 1'b0;
         if (en[g]) begin
            if (sync || !en_q || cnt_q >= d_q - DIVW'(1)) begin
               cnt_nxt = '0;
               load    = 1'b1;
            end else begin
               cnt_nxt = cnt_q + DIVW'(1);
            end
         end else begin
            cnt_nxt = '0;
         end
         if (load && pv_q) begin
            d_nxt  = p_q;
            pv_nxt = 1'b0;
         end
         if (acc[g]) pv_nxt = 1'b1;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            d_q    <= DIVW'(DEF_DIV);
            cnt_q  <= '0;
            pv_q   <= 1'b0;
            en_q   <= 1'b0;
            div_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            d_q    <= d_nxt;
            cnt_q  <= cnt_nxt;
            pv_q   <= pv_nxt;
            en_q   <= en[g];
            div_q  <= en[g] && ({1'b0, cnt_nxt} < half_up(d_nxt));
            tick_q <= en[g] && (cnt_nxt == '0);
         end
      end

      always_ff @(posedge clk) begin
         if (acc[g]) p_q <= sat_div(cfg_div);
      end

      assign pv_vec[g]  = pv_q;
      assign div_clk[g] = div_q;
      assign tick[g]    = tick_q;
   end

endmodule

// File: tb/tb_gen_clk_div.sv
// Directed bench for gen_clk_div: reset, even/odd ratios, mid-period change,
// sync alignment, ratio saturation, out-of-range channel and reset with a pending ratio.
module tb_gen_clk_div;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] en;
   logic       sync;
   logic       cfg_valid;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_div;
   logic       cfg_ready;
   logic [2:0] div_clk;
   logic [2:0] tick;

   int total = 0;
   int bad   = 0;

   gen_clk_div #(.NCH(3), .DIVW(8), .DEF_DIV(2)) dut (
      .clk(clk), .rst(rst), .en(en), .sync(sync),
      .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
      .cfg_ready(cfg_ready), .div_clk(div_clk), .tick(tick)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks both channel waveforms cycle by cycle (bit k = cycle k), stepping after each.
   task automatic seq(input string tag, input logic [15:0] d0, input logic [15:0] t0,
                      input logic [15:0] d1, input logic [15:0] t1, input int n);
      for (int k = 0; k < n; k++) begin
         chk({tag, " div0"}, 32'(div_clk[0]), 32'(d0[k]));
         chk({tag, " tick0"}, 32'(tick[0]), 32'(t0[k]));
         chk({tag, " div1"}, 32'(div_clk[1]), 32'(d1[k]));
         chk({tag, " tick1"}, 32'(tick[1]), 32'(t1[k]));
         chk({tag, " ch2"}, 32'({div_clk[2], tick[2]}), 32'd0);
         step();
      end
   endtask

   task automatic cfg(input logic [1:0] ch, input logic [7:0] dv);
      cfg_ch    = ch;
      cfg_div   = dv;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1; en = '0; sync = 1'b0; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd9;
      step();
      step();
      chk("reset div_clk", 32'(div_clk), 32'd0);
      chk("reset tick", 32'(tick), 32'd0);
      chk("reset ready", 32'(cfg_ready), 32'd1);

      // Divide-by-2 from reset
      rst = 1'b0; cfg_valid = 1'b0; en = 3'b001;
      #1;
      chk("post-reset ready", 32'(cfg_ready), 32'd1);
      step();
      seq("div2", 16'h5, 16'h5, 16'h0, 16'h0, 4);

      // Odd ratio 5 programmed while disabled
      en = 3'b000;
      step();
      chk("disabled div", 32'(div_clk), 32'd0);
      cfg(2'd0, 8'd5);
      chk("pending ready", 32'(cfg_ready), 32'd0);
      step();
      chk("disabled tick", 32'(tick), 32'd0);
      en = 3'b001;
      step();
      seq("div5", 16'h00E7, 16'h0021, 16'h0, 16'h0, 10);
      chk("div5 ready", 32'(cfg_ready), 32'd1);

      // Mid-period change from 4 to 6
      en = 3'b000;
      step();
      cfg(2'd0, 8'd4);
      en = 3'b001;
      step();
      chk("d4 k0 div", 32'(div_clk[0]), 32'd1);
      chk("d4 k0 tick", 32'(tick[0]), 32'd1);
      step();
      chk("d4 k1 div", 32'(div_clk[0]), 32'd1);
      chk("d4 k1 ready", 32'(cfg_ready), 32'd1);
      cfg(2'd0, 8'd6);
      chk("d4 k2 div", 32'(div_clk[0]), 32'd0);
      chk("d4 k2 ready", 32'(cfg_ready), 32'd0);
      step();
      chk("d4 k3 div", 32'(div_clk[0]), 32'd0);
      chk("d4 k3 ready", 32'(cfg_ready), 32'd0);
      step();
      chk("d6 wrap ready", 32'(cfg_ready), 32'd1);
      seq("div6", 16'h0047, 16'h0041, 16'h0, 16'h0, 7);

      // Sync alignment: ch0 D=3, ch1 D=6
      cfg(2'd0, 8'd3);
      cfg(2'd1, 8'd6);
      en = 3'b011;
      for (int i = 0; i < 5; i++) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      seq("sync", 16'h06DB, 16'h0249, 16'h01C7, 16'h0041, 12);

      // cfg_div=1 saturates to 2
      cfg(2'd1, 8'd1);
      chk("ch1 pending ready", 32'(cfg_ready), 32'd0);
      sync = 1'b1;
      step();
      sync = 1'b0;
      seq("sat2", 16'h001B, 16'h0009, 16'h0015, 16'h0015, 6);

      // Out-of-range channel is ready and dropped
      cfg_ch = 2'd3; cfg_div = 8'd9; cfg_valid = 1'b1;
      #1;
      chk("oor ready", 32'(cfg_ready), 32'd1);
      step();
      cfg_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cfg_ch = 2'(c);
         #1;
         chk("oor no pv", 32'(cfg_ready), 32'd1);
      end
      seq("oor wave", 16'h002D, 16'h0024, 16'h002A, 16'h002A, 6);

      // Reset with a pending ratio discards it and restores DEF_DIV
      cfg(2'd0, 8'd7);
      chk("pv before rst", 32'(cfg_ready), 32'd0);
      rst = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd9;
      #1;
      chk("ready in rst", 32'(cfg_ready), 32'd1);
      step();
      chk("rst div_clk", 32'(div_clk), 32'd0);
      chk("rst tick", 32'(tick), 32'd0);
      rst = 1'b0; cfg_valid = 1'b0;
      #1;
      chk("pv cleared", 32'(cfg_ready), 32'd1);
      step();
      seq("after rst", 16'h5, 16'h5, 16'h5, 16'h5, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
